// File: rtl/lut_eval_pkg.sv
// Shared types and the truth-table index rule
// for the streaming LUT evaluator.
package lut_eval_pkg;

    localparam int K_MAX  = 6;
    localparam int TW_MAX = 1 << K_MAX;
    localparam int DEF_K  = 4;
    localparam int DEF_TW = 1 << DEF_K;
    localparam logic [DEF_TW-1:0] DEF_TT = 16'hBDF1;

    typedef logic [TW_MAX-1:0] tt_max_t;
    typedef logic [K_MAX-1:0]  x_max_t;

    // Operand x[0] is the MSB of the table address.
    function automatic logic tt_lookup(
        input tt_max_t tt,
        input x_max_t  x,
        input int      k
    );
        logic [K_MAX-1:0] addr;
        addr = '0;
        for (int i = 0; i < K_MAX; i++) begin
            if (i < k) begin
                addr = {addr[K_MAX-2:0], x[i]};
            end
        end
        return tt[addr];
    endfunction

endpackage

// File: rtl/lut_bank.sv
// Shadow/active truth-table storage for all
// channels plus combinational lookup.
module lut_bank
    import lut_eval_pkg::*;
#(
    parameter int K  = 4,
    parameter int CH = 2,
    parameter int CW = 1,
    parameter logic [(1<<K)-1:0] DEFAULT_TT = DEF_TT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [(1<<K)-1:0] cfg_tt,
    input  logic             cfg_commit,
    input  logic [CH*K-1:0]  in_data,
    output logic [CH-1:0]    res
);

    localparam int TW = 1 << K;

    logic [TW-1:0] shadow [CH];
    logic [TW-1:0] active [CH];

    // Commit reads the pre-write shadow, so a same-cycle
    // write only lands in shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                shadow[c] <= DEFAULT_TT;
                active[c] <= DEFAULT_TT;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (cfg_we && cfg_ch == CW'(c)) begin
                    shadow[c] <= cfg_tt;
                end
                if (cfg_commit) begin
                    active[c] <= shadow[c];
                end
            end
        end
    end

    always_comb begin
        res = '0;
        for (int c = 0; c < CH; c++) begin
            res[c] = tt_lookup(
                tt_max_t'(active[c]),
                x_max_t'(in_data[c*K +: K]),
                K
            );
        end
    end

endmodule

// File: rtl/lut_stream_eval.sv
// Two-stage valid/ready pipeline evaluating CH
// programmable K-input truth tables per beat.
module lut_stream_eval
    import lut_eval_pkg::*;
#(
    parameter int K     = 4,
    parameter int CH    = 2,
    parameter logic [(1<<K)-1:0] DEFAULT_TT = DEF_TT,
    parameter int CNT_W = 16,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH*K-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH-1:0]     out_data,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [(1<<K)-1:0] cfg_tt,
    input  logic              cfg_commit,
    output logic [CNT_W-1:0]  beat_cnt
);

    logic          s1_valid;
    logic [CH-1:0] s1_data;
    logic [CH-1:0] lut_res;
    logic          s2_load;
    logic          in_xfer;
    logic          out_xfer;

    lut_bank #(
        .K          (K),
        .CH         (CH),
        .CW         (CW),
        .DEFAULT_TT (DEFAULT_TT)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_tt     (cfg_tt),
        .cfg_commit (cfg_commit),
        .in_data    (in_data),
        .res        (lut_res)
    );

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Lookup happens at accept time against the
    // active tables, so later commits never touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_xfer) begin
                s1_data <= lut_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_xfer && beat_cnt != {CNT_W{1'b1}}) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lut_stream_eval.sv
// Randomized scoreboard bench for lut_stream_eval
// with literal spot checks.
module tb_lut_stream_eval;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_data;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_tt;
    logic        cfg_commit;
    logic [15:0] beat_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [1:0]  out_data2;
    logic [3:0]  beat_cnt2;

    int ntests = 0;
    int nerr   = 0;

    lut_stream_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_tt     (cfg_tt),
        .cfg_commit (cfg_commit),
        .beat_cnt   (beat_cnt)
    );

    lut_stream_eval #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_tt     (cfg_tt),
        .cfg_commit (cfg_commit),
        .beat_cnt   (beat_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: x[0] of the operand vector is the address MSB.
    function automatic logic f_ref(input logic [15:0] tt, input logic [3:0] x);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) idx = idx * 2 + int'(x[i]);
        return tt[idx];
    endfunction

    typedef struct {
        logic [1:0] d;
        int         acc;
    } item_t;

    logic [15:0] m_sh  [2];
    logic [15:0] m_act [2];
    item_t       q [$];
    logic [1:0]  got [$];
    int          got_cyc [$];
    int          dcount;
    int          cyc;
    logic        prev_ov, prev_or;
    logic [1:0]  prev_od;

    always @(negedge clk) begin
        logic exp_ir, exp_ov, acc, dlv;
        logic [1:0] r;
        item_t it;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_sh[c]  = 16'hBDF1;
                m_act[c] = 16'hBDF1;
            end
            q.delete();
            dcount  = 0;
            prev_ov = 1'b0;
            prev_or = 1'b0;
            prev_od = '0;
        end else begin
            exp_ir = (q.size() < 2) || out_ready;
            exp_ov = (q.size() > 0) && (q[0].acc < cyc);
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) chk("out_data", 32'(out_data), 32'(q[0].d));
            if (prev_ov && !prev_or) chk("stall_hold", 32'(out_data), 32'(prev_od));
            chk("beat_cnt", 32'(beat_cnt), (dcount > 65535) ? 32'd65535 : 32'(dcount));
            chk("beat_cnt_sat", 32'(beat_cnt2), (dcount > 15) ? 32'd15 : 32'(dcount));
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
            dlv = exp_ov && out_ready;
            acc = in_valid && exp_ir;
            if (dlv) begin
                void'(q.pop_front());
                dcount++;
                got.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            if (acc) begin
                r[0] = f_ref(m_act[0], in_data[3:0]);
                r[1] = f_ref(m_act[1], in_data[7:4]);
                it.d = r;
                it.acc = cyc + 1;
                q.push_back(it);
            end
            if (cfg_commit) begin
                m_act[0] = m_sh[0];
                m_act[1] = m_sh[1];
            end
            if (cfg_we) m_sh[cfg_ch] = cfg_tt;
            cyc++;
        end
    end

    task automatic cyc_in(input logic v, input logic [7:0] d, input logic we,
                          input logic ch, input logic [15:0] tt, input logic cm);
        in_valid   = v;
        in_data    = d;
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_tt     = tt;
        cfg_commit = cm;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        cyc_in(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_tt = '0;
        cfg_commit = 1'b0;
        cyc = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        do_reset();

        // Index rule and two-cycle latency
        beat(8'h00);
        chk("lat_s1_empty_out", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("x0000_result", 32'(out_data), 32'h3);
        beat(8'h08);
        beat(8'h01);
        idle(3);
        chk("x3_only", 32'(got[1]), 32'h2);
        chk("x0_only", 32'(got[2]), 32'h3);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            beat({v, v});
        end
        idle(3);

        // Back-to-back stream
        do_reset();
        for (int i = 0; i < 32; i++) beat(8'($urandom));
        idle(3);
        chk("b2b_count", 32'(got.size()), 32'd32);
        chk("b2b_span", 32'(got_cyc[31] - got_cyc[0]), 32'd31);
        chk("b2b_beat_cnt", 32'(beat_cnt), 32'd32);

        // Downstream stall mid-stream
        for (int i = 0; i < 3; i++) beat(8'($urandom));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(8'($urandom));
            if (i == 3) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'($urandom));
        idle(4);

        // Shadow write, commit with same-cycle beat
        do_reset();
        cyc_in(1'b0, 8'h00, 1'b1, 1'b1, 16'h8000, 1'b0);
        beat(8'h00);
        cyc_in(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1);
        beat(8'hF0);
        beat(8'h00);
        idle(3);
        chk("no_commit_old", 32'(got[0]), 32'h3);
        chk("commit_same_old", 32'(got[1]), 32'h3);
        chk("new_x1111", 32'(got[2]), 32'h3);
        chk("new_x0000", 32'(got[3]), 32'h1);

        // Write and commit in the same cycle
        got.delete();
        cyc_in(1'b0, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b1);
        beat(8'hF0);
        cyc_in(1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0);
        cyc_in(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1);
        beat(8'hF0);
        beat(8'h00);
        idle(3);
        chk("we_commit_same", 32'(got[0]), 32'h3);
        chk("zero_tables_a", 32'(got[1]), 32'h0);
        chk("zero_tables_b", 32'(got[2]), 32'h0);

        // Randomized traffic and config
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cyc_in(1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                   16'($urandom), $urandom_range(0, 15) == 0);
        end
        out_ready = 1'b1;
        idle(4);
        chk("sat_cnt4", 32'(beat_cnt2), 32'd15);

        // Reset with beats in flight
        beat(8'h00);
        beat(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        beat(8'h00);
        idle(3);
        chk("midrst_tables", 32'(got[0]), 32'h3);
        chk("midrst_one_beat", 32'(got.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nerr);
        $finish;
    end

endmodule
